// File: rtl/rr_grant_arbiter_if.sv
// rr_grant_arbiter_if: request/grant bundle between the requester bank and the arbiter.
// Signals:
//   en_i       arbitration enable (gates new grants only)
//   req_i      request vector, bit i = requester i
//   release_i  current owner finished
//   gnt_o      registered one-hot grant
//   gnt_idx_o  registered binary index of the granted requester
//   gnt_vld_o  high while a grant is held
//   timeout_o  one-cycle pulse on a forced release
// Modports: master drives requests, slave is the arbiter.
interface rr_grant_arbiter_if;
    logic       en_i;
    logic [7:0] req_i;
    logic       release_i;
    logic [7:0] gnt_o;
    logic [2:0] gnt_idx_o;
    logic       gnt_vld_o;
    logic       timeout_o;
    modport master (
        output en_i, req_i, release_i,
        input  gnt_o, gnt_idx_o, gnt_vld_o, timeout_o
    );
    modport slave (
        input  en_i, req_i, release_i,
        output gnt_o, gnt_idx_o, gnt_vld_o, timeout_o
    );
endinterface

// File: rtl/rr_grant_arbiter.sv
// rr_grant_arbiter: eight-way round-robin arbiter with held grant, owner release and forced-release timeout.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   bus  rr_grant_arbiter_if.slave (en_i, req_i, release_i in; gnt_o, gnt_idx_o, gnt_vld_o, timeout_o out)
// Parameter MAX_HOLD: max cycles a grant may stay asserted, 0 = unlimited, 0..255.
module rr_grant_arbiter #(
    parameter int MAX_HOLD = 15
) (
    input  logic                      clk,
    input  logic                      rst,
    rr_grant_arbiter_if.slave         bus
);
    typedef enum logic {IDLE, BUSY} state_t;
    localparam logic [7:0] MAX_HOLD_C = 8'(MAX_HOLD);
    state_t     state_q, state_d;
    logic [2:0] ptr_q, ptr_d;
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] gnt_q, gnt_d;
    logic [2:0] idx_q, idx_d;
    logic       vld_q, vld_d;
    logic       to_q, to_d;
    logic [15:0] dbl;
    logic [7:0]  rot;
    logic [2:0]  off;
    logic [2:0]  pick;
    logic        owner_done;
    logic        forced;
    // Rotate requests so that slot ptr lands at bit 0; the lowest set bit of the
    // rotated vector is then the first requester at or after ptr.
    always_comb begin
        dbl = {bus.req_i, bus.req_i} >> ptr_q;
        rot = dbl[7:0];
        off = 3'd0;
        for (int i = 7; i >= 0; i--)
            if (rot[i]) off = 3'(i);
        pick = ptr_q + off;
    end
    // Owner release outranks the timeout, so a release on the limit edge is not reported as a timeout.
    assign owner_done = bus.release_i || !bus.req_i[idx_q];
    assign forced     = (MAX_HOLD_C != 8'd0) && (cnt_q == MAX_HOLD_C);
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        gnt_d   = gnt_q;
        idx_d   = idx_q;
        vld_d   = vld_q;
        to_d    = 1'b0;
        if (state_q == IDLE) begin
            if (bus.en_i && |bus.req_i) begin
                gnt_d   = 8'd1 << pick;
                idx_d   = pick;
                vld_d   = 1'b1;
                cnt_d   = 8'd1;
                state_d = BUSY;
            end
        end else if (owner_done || forced) begin
            gnt_d   = 8'd0;
            vld_d   = 1'b0;
            cnt_d   = 8'd0;
            ptr_d   = idx_q + 3'd1;
            to_d    = !owner_done;
            state_d = IDLE;
        end else begin
            cnt_d = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= 3'd0;
            cnt_q   <= 8'd0;
            gnt_q   <= 8'd0;
            idx_q   <= 3'd0;
            vld_q   <= 1'b0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
            idx_q   <= idx_d;
            vld_q   <= vld_d;
            to_q    <= to_d;
        end
    end
    assign bus.gnt_o     = gnt_q;
    assign bus.gnt_idx_o = idx_q;
    assign bus.gnt_vld_o = vld_q;
    assign bus.timeout_o = to_q;
endmodule

// File: tb/tb_rr_grant_arbiter.sv
// tb_rr_grant_arbiter: directed bench with a behavioural round-robin model checked every cycle.
module tb_rr_grant_arbiter;
    localparam int MH = 4;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int n_chk = 0;
    int n_fail = 0;
    rr_grant_arbiter_if bus();
    rr_grant_arbiter #(.MAX_HOLD(MH)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: integer pointer and owner, modular scan from the pointer.
    int   m_ptr, m_owner, m_hold;
    bit   m_busy, m_done;
    logic [7:0] e_gnt;
    logic [2:0] e_idx;
    bit   e_vld, e_to;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_ptr = 0; m_owner = 0; m_hold = 0; m_busy = 0;
            e_gnt = 0; e_idx = 0; e_vld = 0; e_to = 0;
        end else begin
            e_to = 0;
            m_done = 0;
            if (!m_busy) begin
                if (bus.en_i && bus.req_i != 0) begin
                    for (int i = 0; i < 8; i++)
                        if (!m_busy && bus.req_i[(m_ptr + i) % 8]) begin
                            m_owner = (m_ptr + i) % 8;
                            m_busy = 1;
                            m_hold = 1;
                        end
                    e_gnt = 8'(1 << m_owner);
                    e_idx = 3'(m_owner);
                    e_vld = 1;
                end
            end else begin
                if (bus.release_i || !bus.req_i[m_owner]) m_done = 1;
                else if (MH != 0 && m_hold == MH) begin m_done = 1; e_to = 1; end
                else m_hold = (m_hold < 255) ? m_hold + 1 : 255;
                if (m_done) begin
                    m_busy = 0;
                    e_gnt = 0;
                    e_vld = 0;
                    m_ptr = (m_owner + 1) % 8;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("model_gnt", 32'(bus.gnt_o), 32'(e_gnt));
            chk("model_idx", 32'(bus.gnt_idx_o), 32'(e_idx));
            chk("model_vld", 32'(bus.gnt_vld_o), 32'(e_vld));
            chk("model_to",  32'(bus.timeout_o), 32'(e_to));
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    int vld_cnt;
    bit seen_to;
    initial begin
        bus.en_i = 1'b1; bus.req_i = 8'hFF; bus.release_i = 1'b0;
        step(3);
        chk("rst_gnt", 32'(bus.gnt_o), 32'h00);
        chk("rst_vld", 32'(bus.gnt_vld_o), 32'h0);
        chk("rst_idx", 32'(bus.gnt_idx_o), 32'h0);
        chk("rst_to",  32'(bus.timeout_o), 32'h0);
        bus.en_i = 1'b0; bus.req_i = 8'h0C;
        rst = 1'b0;
        step(5);
        chk("gate_vld", 32'(bus.gnt_vld_o), 32'h0);
        bus.en_i = 1'b1;
        step(1);
        chk("en_gnt", 32'(bus.gnt_o), 32'h04);
        chk("en_idx", 32'(bus.gnt_idx_o), 32'h2);
        // rotation 2,3,2,3 with one idle cycle between grants
        bus.release_i = 1'b1; step(1); bus.release_i = 1'b0;
        chk("rot_gap1", 32'(bus.gnt_vld_o), 32'h0);
        step(1); chk("rot_idx3a", 32'(bus.gnt_idx_o), 32'h3);
        bus.release_i = 1'b1; step(1); bus.release_i = 1'b0;
        chk("rot_gap2", 32'(bus.gnt_vld_o), 32'h0);
        step(1); chk("rot_idx2b", 32'(bus.gnt_idx_o), 32'h2);
        bus.release_i = 1'b1; step(1); bus.release_i = 1'b0;
        step(1); chk("rot_gnt3b", 32'(bus.gnt_o), 32'h08);
        bus.release_i = 1'b1; step(1); bus.release_i = 1'b0;
        // wrap: ptr now 4, so 8'h81 picks 7, then wraps to 0
        bus.req_i = 8'h81;
        step(1); chk("wrap_idx7", 32'(bus.gnt_idx_o), 32'h7);
        bus.release_i = 1'b1; step(1); bus.release_i = 1'b0;
        step(1); chk("wrap_gnt0", 32'(bus.gnt_o), 32'h01);
        bus.release_i = 1'b1; bus.req_i = 8'h00; step(1); bus.release_i = 1'b0;
        // timeout: grant held exactly MH cycles, then one-cycle pulse
        bus.req_i = 8'h01;
        vld_cnt = 0; seen_to = 0;
        for (int i = 0; i < 20 && !seen_to; i++) begin
            step(1);
            if (bus.gnt_vld_o) vld_cnt++;
            if (bus.timeout_o) seen_to = 1;
        end
        chk("to_seen", 32'(seen_to), 32'h1);
        chk("to_hold", 32'(vld_cnt), 32'(MH));
        chk("to_gnt_low", 32'(bus.gnt_vld_o), 32'h0);
        step(1);
        chk("to_pulse_end", 32'(bus.timeout_o), 32'h0);
        chk("to_regrant", 32'(bus.gnt_o), 32'h01);
        // release on the limit edge: cnt reaches MH after MH-1 more edges
        step(MH - 1);
        bus.release_i = 1'b1; step(1); bus.release_i = 1'b0;
        chk("prio_vld", 32'(bus.gnt_vld_o), 32'h0);
        chk("prio_to", 32'(bus.timeout_o), 32'h0);
        step(1); chk("drop_grant", 32'(bus.gnt_vld_o), 32'h1);
        step(1); bus.req_i = 8'h00;
        step(1);
        chk("drop_vld", 32'(bus.gnt_vld_o), 32'h0);
        chk("drop_to", 32'(bus.timeout_o), 32'h0);
        // asynchronous reset mid-grant
        bus.req_i = 8'h10;
        step(1);
        chk("busy_idx4", 32'(bus.gnt_idx_o), 32'h4);
        #2 rst = 1'b1;
        #1;
        chk("async_gnt", 32'(bus.gnt_o), 32'h00);
        chk("async_vld", 32'(bus.gnt_vld_o), 32'h0);
        chk("async_idx", 32'(bus.gnt_idx_o), 32'h0);
        bus.req_i = 8'h00;
        step(2);
        rst = 1'b0;
        step(3);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
